// File: rtl/pipe_rd_responder.sv
// Responder end of the direct AFU-to-AFU read pipe: buffers producer lines and pairs them in order with consumer read tags.
// Optional response counter on resp_count is built when PIPE_RESP_STATS_EN is defined.
`ifndef IF_TAG
`define IF_TAG 16
`endif

module pipe_rd_responder #(
  parameter int TAG_WIDTH       = `IF_TAG,
  parameter int DATA_DEPTH_BITS = 6,
  parameter int REQ_DEPTH_BITS  = 6
) (
  input  logic                 clk,
  input  logic                 reset_interface,
  input  logic                 pipe_enable,
  input  logic                 pipe_flush,
  output logic                 flush_done,
  input  logic                 pipe_wr_valid,
  input  logic [TAG_WIDTH-1:0] pipe_wr_tag,
  input  logic [511:0]         pipe_wr_data,
  output logic                 pipe_wr_ready,
  output logic                 pipe_wr_ack_valid,
  output logic [TAG_WIDTH-1:0] pipe_wr_ack_tag,
  input  logic                 usr_pipe_tx_rd_valid,
  input  logic [TAG_WIDTH-1:0] usr_pipe_tx_rd_tag,
  output logic                 usr_pipe_tx_rd_ready,
  output logic                 usr_pipe_rx_rd_valid,
  output logic [TAG_WIDTH-1:0] usr_pipe_rx_rd_tag,
  output logic [511:0]         usr_pipe_rx_rd_data,
  input  logic                 usr_pipe_rx_rd_ready,
  output logic [31:0]          resp_count
);

  localparam int LINE_DEPTH = 1 << DATA_DEPTH_BITS;
  localparam int REQ_DEPTH  = 1 << REQ_DEPTH_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DATA_DEPTH_BITS:0] line_wr_ptr_q, line_wr_ptr_d;
  logic [DATA_DEPTH_BITS:0] line_rd_ptr_q, line_rd_ptr_d;
  logic [REQ_DEPTH_BITS:0]  req_wr_ptr_q, req_wr_ptr_d;
  logic [REQ_DEPTH_BITS:0]  req_rd_ptr_q, req_rd_ptr_d;

  logic [511:0]         line_mem_q [LINE_DEPTH];
  logic [TAG_WIDTH-1:0] req_mem_q  [REQ_DEPTH];

  logic                 out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
  logic [511:0]         out_data_q, out_data_d;

  logic                 ack_valid_q, ack_valid_d;
  logic [TAG_WIDTH-1:0] ack_tag_q, ack_tag_d;
  logic                 flush_done_q, flush_done_d;

  logic line_empty, line_full, req_empty, req_full;
  logic wr_ready, rd_req_ready;
  logic wr_fire, rd_req_fire, pair_fire, out_free;
  logic [511:0] pair_line;

  assign line_empty = (line_wr_ptr_q == line_rd_ptr_q);
  assign line_full  = (line_wr_ptr_q[DATA_DEPTH_BITS] != line_rd_ptr_q[DATA_DEPTH_BITS]) &&
                      (line_wr_ptr_q[DATA_DEPTH_BITS-1:0] == line_rd_ptr_q[DATA_DEPTH_BITS-1:0]);
  assign req_empty  = (req_wr_ptr_q == req_rd_ptr_q);
  assign req_full   = (req_wr_ptr_q[REQ_DEPTH_BITS] != req_rd_ptr_q[REQ_DEPTH_BITS]) &&
                      (req_wr_ptr_q[REQ_DEPTH_BITS-1:0] == req_rd_ptr_q[REQ_DEPTH_BITS-1:0]);

  assign wr_ready     = (state_q == ST_RUN) && !line_full;
  assign rd_req_ready = ((state_q == ST_RUN) || (state_q == ST_FLUSH)) && !req_full;

  assign wr_fire     = pipe_wr_valid && wr_ready;
  assign rd_req_fire = usr_pipe_tx_rd_valid && rd_req_ready;
  assign out_free    = !out_valid_q || usr_pipe_rx_rd_ready;

  // During flush a request with no line left to match is answered with an all-zero line.
  assign pair_fire = !req_empty && out_free && (!line_empty || (state_q == ST_FLUSH));
  assign pair_line = line_empty ? '0 : line_mem_q[line_rd_ptr_q[DATA_DEPTH_BITS-1:0]];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    state_d       = state_q;
    line_wr_ptr_d = line_wr_ptr_q;
    line_rd_ptr_d = line_rd_ptr_q;
    req_wr_ptr_d  = req_wr_ptr_q;
    req_rd_ptr_d  = req_rd_ptr_q;
    out_valid_d   = out_valid_q;
    out_tag_d     = out_tag_q;
    out_data_d    = out_data_q;
    ack_valid_d   = wr_fire;
    ack_tag_d     = ack_tag_q;
    flush_done_d  = 1'b0;

    if (wr_fire) begin
      line_wr_ptr_d = line_wr_ptr_q + (DATA_DEPTH_BITS+1)'(1);
      ack_tag_d     = pipe_wr_tag;
    end

    if (rd_req_fire) begin
      req_wr_ptr_d = req_wr_ptr_q + (REQ_DEPTH_BITS+1)'(1);
    end

    if (pair_fire) begin
      req_rd_ptr_d = req_rd_ptr_q + (REQ_DEPTH_BITS+1)'(1);
      if (!line_empty) begin
        line_rd_ptr_d = line_rd_ptr_q + (DATA_DEPTH_BITS+1)'(1);
      end
      out_valid_d = 1'b1;
      out_tag_d   = req_mem_q[req_rd_ptr_q[REQ_DEPTH_BITS-1:0]];
      out_data_d  = pair_line;
    end else if (usr_pipe_rx_rd_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pipe_enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pipe_flush) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // A request landing on the exit edge would be stranded, so hold FLUSH one more cycle for it.
        if (line_empty && req_empty && !out_valid_q && !rd_req_fire) begin
          state_d      = ST_IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_interface) begin
      state_q       <= ST_IDLE;
      line_wr_ptr_q <= '0;
      line_rd_ptr_q <= '0;
      req_wr_ptr_q  <= '0;
      req_rd_ptr_q  <= '0;
      out_valid_q   <= 1'b0;
      out_tag_q     <= '0;
      out_data_q    <= '0;
      ack_valid_q   <= 1'b0;
      ack_tag_q     <= '0;
      flush_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_wr_ptr_q <= line_wr_ptr_d;
      line_rd_ptr_q <= line_rd_ptr_d;
      req_wr_ptr_q  <= req_wr_ptr_d;
      req_rd_ptr_q  <= req_rd_ptr_d;
      out_valid_q   <= out_valid_d;
      out_tag_q     <= out_tag_d;
      out_data_q    <= out_data_d;
      ack_valid_q   <= ack_valid_d;
      ack_tag_q     <= ack_tag_d;
      flush_done_q  <= flush_done_d;
    end
  end

  // NOTE: buffer storage is not reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      line_mem_q[line_wr_ptr_q[DATA_DEPTH_BITS-1:0]] <= pipe_wr_data;
    end
    if (rd_req_fire) begin
      req_mem_q[req_wr_ptr_q[REQ_DEPTH_BITS-1:0]] <= usr_pipe_tx_rd_tag;
    end
  end

`ifdef PIPE_RESP_STATS_EN
  logic [31:0] resp_count_q, resp_count_d;

  always_comb begin
    resp_count_d = resp_count_q;
    if (out_valid_q && usr_pipe_rx_rd_ready) begin
      resp_count_d = resp_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_interface) begin
      resp_count_q <= '0;
    end else begin
      resp_count_q <= resp_count_d;
    end
  end

  assign resp_count = resp_count_q;
`else
  assign resp_count = 32'd0;
`endif

  assign flush_done           = flush_done_q;
  assign pipe_wr_ready        = wr_ready;
  assign pipe_wr_ack_valid    = ack_valid_q;
  assign pipe_wr_ack_tag      = ack_tag_q;
  assign usr_pipe_tx_rd_ready = rd_req_ready;
  assign usr_pipe_rx_rd_valid = out_valid_q;
  assign usr_pipe_rx_rd_tag   = out_tag_q;
  assign usr_pipe_rx_rd_data  = out_data_q;

endmodule
